// File: rtl/disp_bcd_conv.sv
// 16-bit binary to four-digit display formatter: decimal via shift-and-add-3
// (saturating at 9999) or hex via nibble split. Digits hold until each done.
module disp_bcd_conv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3
);

  // state | meaning
  // IDLE  | waiting for start; digits hold last result
  // CONV  | hex: one cycle to publish; decimal: 14 shift-and-add-3 iterations
  typedef enum logic {IDLE, CONV} state_t;

  state_t      state;
  logic [15:0] operand;
  logic [15:0] scratch;
  logic [15:0] scratch_adj;
  logic [15:0] scratch_nxt;
  logic [3:0]  cnt;
  logic        mode_hex;
  logic        pend_ovf;

  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    // decimal operand is at most 14 bits, so bit 13 is its MSB
    scratch_nxt = {scratch_adj[14:0], operand[13]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      operand  <= '0;
      scratch  <= '0;
      cnt      <= '0;
      mode_hex <= 1'b0;
      pend_ovf <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      d0       <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CONV;
            busy     <= 1'b1;
            mode_hex <= hex_mode;
            scratch  <= '0;
            cnt      <= '0;
            if (hex_mode) begin
              operand  <= value;
              pend_ovf <= 1'b0;
            end else if (value > 16'd9999) begin
              operand  <= 16'd9999;
              pend_ovf <= 1'b1;
            end else begin
              operand  <= {2'b00, value[13:0]};
              pend_ovf <= 1'b0;
            end
          end
        end
        CONV: begin
          if (mode_hex) begin
            {d3, d2, d1, d0} <= operand;
            ovf   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            scratch <= scratch_nxt;
            operand <= operand << 1;
            cnt     <= cnt + 4'd1;
            if (cnt == 4'd13) begin
              {d3, d2, d1, d0} <= scratch_nxt;
              ovf   <= pend_ovf;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_bcd_conv.sv
// Scoreboard bench for disp_bcd_conv: driver pushes expected digits from an
// arithmetic model, a monitor pops and compares on every done pulse.
module tb_disp_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] value;
  logic        hex_mode;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  d0, d1, d2, d3;

  disp_bcd_conv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value), .hex_mode(hex_mode),
    .busy(busy), .done(done), .ovf(ovf), .d0(d0), .d1(d1), .d2(d2), .d3(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic        ovf;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [16:0] last = '0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: saturate then split by powers of ten, or split into nibbles.
  function automatic exp_t model(input logic [15:0] v, input logic hx);
    exp_t e;
    int   c;
    e.lat = hx ? 1 : 14;
    e.t0  = 0;
    if (hx) begin
      e.digits = v;
      e.ovf    = 1'b0;
    end else begin
      c     = (v > 9999) ? 9999 : int'(v);
      e.ovf = (v > 9999);
      e.digits = {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last      = '0;
      prev_done = 1'b0;
    end else begin
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done) begin
        check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending conversion (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("digits", {16'd0, d3, d2, d1, d0}, {16'd0, e.digits});
          check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          check("latency", cyc - e.t0, e.lat);
          last = {e.ovf, e.digits};
        end
      end else if (busy) begin
        check("hold_during_conv", {15'd0, ovf, d3, d2, d1, d0}, {15'd0, last});
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: got busy=1 after %0d cycles expected busy=0", n);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] v, input logic hx);
    exp_t e;
    wait_idle();
    e    = model(v, hx);
    e.t0 = cyc + 1;
    sb.push_back(e);
    start    = 1'b1;
    value    = v;
    hex_mode = hx;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic check_zero(input string name);
    check(name, {13'd0, busy, done, ovf, d3, d2, d1, d0}, 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    int          n;
    rst_n    = 1'b0;
    start    = 1'b0;
    value    = '0;
    hex_mode = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("idle_after_reset");

    issue(16'd0, 1'b0);
    issue(16'd1234, 1'b0);
    issue(16'd9999, 1'b0);
    issue(16'd10000, 1'b0);
    issue(16'd65535, 1'b0);
    issue(16'hBEEF, 1'b1);
    issue(16'd42, 1'b0);

    // start in mid-conversion must be dropped
    issue(16'd5678, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    value = 16'd1111;
    hex_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // reset mid-conversion aborts with no done
    issue(16'd4321, 1'b0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero("async_reset_abort");
    #10;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_zero("no_done_after_abort");
    issue(16'd4321, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom % 4)
        0: v = 16'($urandom);
        1: v = 16'(9990 + $urandom % 20);
        2: v = 16'($urandom % 10000);
        default: v = ($urandom % 2) ? 16'hFFFF : 16'h0000;
      endcase
      issue(v, 1'($urandom % 2));
      repeat ($urandom % 3) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
